// File: rtl/ttl_pkg.sv
// Shared definitions for the ttl_74148_sync priority encoder: FSM encoding
// and the strobe-width legality check.
package ttl_pkg;

  localparam int TTL_DEFAULT_WIDTH_IN = 8;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  function automatic bit width_in_legal(input int w);
    return (w >= 2) && ((w & (w - 1)) == 0);
  endfunction

endpackage

// File: rtl/ttl_prio_pick.sv
// Combinational priority pick: first set pending bit found when searching
// downward from 'start' with wrap-around.
module ttl_prio_pick #(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = $clog2(WIDTH_IN)
) (
  input  logic [WIDTH_IN-1:0]  pending,
  input  logic [WIDTH_OUT-1:0] start,
  output logic [WIDTH_OUT-1:0] index,
  output logic                 any
);

  // rot[j] is line (start - j) mod WIDTH_IN, so the lowest set j wins
  logic [WIDTH_IN-1:0] rot;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH_IN; gi++) begin : g_rot
      localparam logic [WIDTH_OUT-1:0] OFS = WIDTH_OUT'(gi);
      assign rot[gi] = pending[start - OFS];
    end
  endgenerate

  always_comb begin
    index = '0;
    any   = |rot;
    for (int j = WIDTH_IN - 1; j >= 0; j--) begin
      if (rot[j]) index = start - WIDTH_OUT'(j);
    end
  end

endmodule

// File: rtl/ttl_74148_sync.sv
// Clocked 8-to-3 priority encoder with pending-request latch and valid/ready
// delivery. Define TTL_ROUND_ROBIN_EN for rotating priority instead of fixed.
module ttl_74148_sync
  import ttl_pkg::*;
#(
  parameter int WIDTH_IN  = TTL_DEFAULT_WIDTH_IN,
  parameter int WIDTH_OUT = $clog2(WIDTH_IN)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 EI_bar,
  input  logic [WIDTH_IN-1:0]  I_bar,
  output logic [WIDTH_OUT-1:0] A,
  output logic                 valid,
  input  logic                 ready,
  output logic                 GS_bar,
  output logic                 EO_bar,
  output logic                 overflow
);

  generate
    if (!width_in_legal(WIDTH_IN)) begin : g_bad_width
      $error("ttl_74148_sync: WIDTH_IN must be a power of two >= 2");
    end
  endgenerate

  logic [WIDTH_IN-1:0]  prev_reg;
  logic [WIDTH_IN-1:0]  pending_reg, pending_next;
  logic [WIDTH_IN-1:0]  capture, clr;
  logic [WIDTH_OUT-1:0] a_reg, a_next;
  logic [WIDTH_OUT-1:0] start, pick_idx;
  logic                 pick_any, load, ovf_reg;
  state_t               state_reg, state_next;

  // Falls are still tracked while disabled so re-enabling cannot fake a strobe
  assign capture = EI_bar ? '0 : (prev_reg & ~I_bar);

`ifdef TTL_ROUND_ROBIN_EN
  logic [WIDTH_OUT-1:0] last_reg;
  assign start = last_reg - WIDTH_OUT'(1);
`else
  assign start = WIDTH_OUT'(WIDTH_IN - 1);
`endif

  ttl_prio_pick #(
    .WIDTH_IN (WIDTH_IN),
    .WIDTH_OUT(WIDTH_OUT)
  ) u_pick (
    .pending(pending_reg),
    .start  (start),
    .index  (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    clr        = '0;
    load       = 1'b0;
    case (state_reg)
      ST_IDLE:    load = pick_any;
      ST_PRESENT: begin
        if (ready) begin
          if (pick_any) load = 1'b1;
          else          state_next = ST_IDLE;
        end
      end
      default:    state_next = ST_IDLE;
    endcase
    if (load) begin
      state_next    = ST_PRESENT;
      a_next        = pick_idx;
      clr[pick_idx] = 1'b1;
    end
  end

  // A new capture on the same bit as this cycle's clear keeps it pending
  assign pending_next = (pending_reg & ~clr) | capture;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_reg    <= '1;
      pending_reg <= '0;
      state_reg   <= ST_IDLE;
      a_reg       <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      prev_reg    <= I_bar;
      pending_reg <= pending_next;
      state_reg   <= state_next;
      a_reg       <= a_next;
      if (|(capture & pending_reg)) ovf_reg <= 1'b1;
    end
  end

`ifdef TTL_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (!reset_n)  last_reg <= '0;
    else if (load) last_reg <= pick_idx;
  end
`endif

  assign A        = a_reg;
  assign valid    = (state_reg == ST_PRESENT);
  assign overflow = ovf_reg;
  assign GS_bar   = EI_bar | ~(valid | (|pending_reg));
  assign EO_bar   = EI_bar | valid | (|pending_reg);

endmodule

// File: doc/ttl_74148_sync.md
# ttl_74148_sync

Clocked 8-to-3 priority encoder with a pending-request latch and a valid/ready handshake. It is the encoding counterpart of the board's 74138-style decoders: it accepts a bank of active-low strobe lines in decoder-output polarity and returns the index of each strobe as a binary code. It sits wherever a decoded select or request bus must be turned back into an index, such as interrupt-source or sound-command sources, and it serialises simultaneous strobes so none is lost.

## Interface
- `WIDTH_IN`, 8: number of strobe lines; power of two, ≥2.
- `WIDTH_OUT`, `$clog2(WIDTH_IN)`: width of the encoded index.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `EI_bar`  in  1: enable, active low. When high, new strobes are ignored.
- `I_bar`  in  WIDTH_IN: strobe lines, active low (74138 output polarity).
- `A`  out  WIDTH_OUT: encoded index, true binary, so it is directly usable as a 74138 `A` input.
- `valid`  out  1: `A` holds an unserved index.
- `ready`  in  1: consumer accepts `A` on a cycle where `valid & ready`.
- `GS_bar`  out  1: group select, low when enabled and any request is outstanding.
- `EO_bar`  out  1: enable out, low when enabled and nothing is outstanding (cascade).
- `overflow`  out  1: sticky; a strobe arrived on a line whose request was already pending.

## Operation
- Edge detect: `prev` register samples `I_bar` every cycle. A fall on line i is `prev[i] & ~I_bar[i]`.
- Capture: when `EI_bar`=0, each fall sets `pending[i]`. When `EI_bar`=1, falls are dropped, but `prev` still tracks the lines.
- If a fall hits a line whose `pending[i]` is already 1, set `overflow`. It clears only on reset.
- FSM with two states:
  - IDLE (`valid`=0): if `pending`≠0, load `A` with the selected index, clear that pending bit, and go to PRESENT.
  - PRESENT (`valid`=1): hold `A` stable while `ready`=0. On `valid & ready`:
    - if `pending`≠0, load the next index in the same cycle and stay in PRESENT (back-to-back service);
    - otherwise go to IDLE.
- Selection: fixed priority, highest set index wins. See Configuration for the alternative.
- Simultaneous set and clear on the same bit: set wins, and the bit stays pending.
- A fall on the line currently held in `A` (its bit is no longer pending) re-arms `pending[i]` with no overflow. That line is served again later.
- `EI_bar`=1 does not stall delivery. Pending requests are still presented and handshaken.
- `GS_bar` = `EI_bar | ~(valid | (|pending))`.
- `EO_bar` = `EI_bar | valid | (|pending)`.
- These two are combinational from registers and `EI_bar`; `I_bar` has no combinational path to any output.

## Timing
- Reset values: `A`=0, `valid`=0, `overflow`=0, `pending`=0, `prev`=all ones, FSM=IDLE.
  - Resulting outputs: `GS_bar`=1; `EO_bar`=`EI_bar`, i.e. 0 when enabled.
- Because `prev` resets to all ones, a line held low through reset counts as one fall on the first enabled cycle after reset.
- Latency: `I_bar[i]` is first sampled low at edge N (it was high at N-1). `pending[i]` is set after edge N, and `valid`=1 with `A`=i after edge N+1.
- Throughput: one index per cycle while `ready`=1 and requests are pending.
- Reset asserted mid-operation: all state returns to reset values after that edge. Any held or pending index is discarded.
- A line held low produces one request only; it must return high before it can strobe again.

## Configuration
- `TTL_ROUND_ROBIN_EN`
  - Defined: a `last` register holds the most recently loaded index (reset 0). The search starts at `(last-1) mod WIDTH_IN` and descends with wrap-around. From reset the first search starts at `WIDTH_IN-1`, identical to fixed priority.
  - Undefined: fixed highest-index priority; no `last` register is built.

## Structure
- Shared package `ttl_pkg`: FSM state encoding (`ST_IDLE`, `ST_PRESENT`) and the `WIDTH_IN` power-of-two legality check.
- One sub-module, `ttl_prio_pick`: purely combinational. It takes the pending vector and the start index and returns the selected index plus an `any` flag, and it is used by both priority modes.
- The top level holds the edge detect, the pending latch, the FSM, and the cascade/overflow logic.

## Test plan
- Reset, then `I_bar[5]` high→low, `ready`=1 → `valid`=1 with `A`=5 two edges after the fall, one beat only, `GS_bar` low during that beat, then `EO_bar`=0.
- `I_bar[2]` and `I_bar[6]` fall in the same cycle, `ready`=1 → beats `A`=6 then `A`=2 on consecutive cycles, `overflow`=0.
- `ready`=0 with `A`=3 held, then `I_bar[3]` strobes again → `A` stays 3; after `ready`=1, beats 3 then 3 again, `overflow`=0. A third strobe on line 3 while it is pending → `overflow`=1 until reset.
- `EI_bar`=1 while `I_bar[1]` falls → no `valid`; `GS_bar`=1 and `EO_bar`=1. A request already pending before `EI_bar` went high is still delivered.
- `reset_n`=0 while `valid`=1 and `pending`=0x0F → the next cycle shows `valid`=0, `A`=0, `overflow`=0, and nothing is delivered afterward.
- With `TTL_ROUND_ROBIN_EN` defined, lines 7 and 4 strobe repeatedly with `ready`=1 → the served sequence alternates 7, 4, 7, 4 (fixed-priority build serves 7 whenever 7 is pending).
